// File: rtl/fphub_div_pkg.sv
// Shared types and widths for the HUB divider issue front end.
// Operand/tag widths are fixed here because the request struct depends on them.
package fphub_div_pkg;

  localparam int M     = 23;
  localparam int E     = 8;
  localparam int TAG_W = 4;
  localparam int OP_W  = M + E + 1;

  localparam int TIMEOUT_DEF = 64;

  // Counter must hold TIMEOUT-1, the last WAIT count before abandoning.
  function automatic int wait_cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

  localparam int WAIT_CNT_W_DEF = wait_cnt_width(TIMEOUT_DEF);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [OP_W-1:0]  x;
    logic [OP_W-1:0]  d;
  } div_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } div_issue_state_t;

endpackage

// File: rtl/fphub_req_fifo.sv
// Small synchronous request FIFO; head word is visible as soon as an entry is present.
// Writes become poppable the cycle after they land, there is no bypass path.
module fphub_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fphub_div_issue_ctrl.sv
// Issue/collect controller around the HUB SRT divider: buffers tagged requests,
// launches one division at a time and returns results in order on a valid/ready port.
module fphub_div_issue_ctrl
  import fphub_div_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         in_x,
  input  logic [OP_W-1:0]         in_d,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OP_W-1:0]         out_res,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_special,
  output logic                    out_timeout,
  output logic                    div_start,
  output logic [OP_W-1:0]         div_x,
  output logic [OP_W-1:0]         div_d,
  input  logic [OP_W-1:0]         div_res,
  input  logic                    div_finish,
  input  logic                    div_computing,
  input  logic                    div_special,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int CNT_W = wait_cnt_width(TIMEOUT);

  div_issue_state_t state_reg;
  div_issue_state_t state_next;

  div_req_t         fifo_wreq;
  div_req_t         fifo_head;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;

  div_req_t         launch_reg;
  logic             special_flag_reg;
  logic [CNT_W-1:0] wait_cnt_reg;

  logic             out_valid_reg;
  logic [OP_W-1:0]  out_res_reg;
  logic [TAG_W-1:0] out_tag_reg;
  logic             out_special_reg;
  logic             out_timeout_reg;

  logic             load_done;
  logic             load_timeout;

  assign fifo_wreq = '{tag: in_tag, x: in_x, d: in_d};
  assign fifo_push = in_valid && in_ready;
  assign in_ready  = !fifo_full;

  fphub_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(div_req_t))
  ) u_req_fifo (
    .clk   (clk),
    .rst_l (rst_l),
    .push  (fifo_push),
    .wdata (fifo_wreq),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  // Only one result may be outstanding, so issue waits for the output slot to drain.
  always_comb begin
    state_next   = state_reg;
    fifo_pop     = 1'b0;
    load_done    = 1'b0;
    load_timeout = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && !out_valid_reg && !div_computing) begin
          state_next = ISSUE;
          fifo_pop   = 1'b1;
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (div_finish) begin
          load_done  = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          load_timeout = 1'b1;
          state_next   = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg        <= IDLE;
      launch_reg       <= '0;
      special_flag_reg <= 1'b0;
      wait_cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (fifo_pop) begin
        launch_reg <= fifo_head;
      end
      if (state_reg == ISSUE) begin
        special_flag_reg <= div_special;
        wait_cnt_reg     <= '0;
      end else if (state_reg == WAIT) begin
        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      out_valid_reg   <= 1'b0;
      out_res_reg     <= '0;
      out_tag_reg     <= '0;
      out_special_reg <= 1'b0;
      out_timeout_reg <= 1'b0;
    end else if (load_done) begin
      out_valid_reg   <= 1'b1;
      out_res_reg     <= div_res;
      out_tag_reg     <= launch_reg.tag;
      out_special_reg <= special_flag_reg;
      out_timeout_reg <= 1'b0;
    end else if (load_timeout) begin
      out_valid_reg   <= 1'b1;
      out_res_reg     <= '0;
      out_tag_reg     <= launch_reg.tag;
      out_special_reg <= 1'b0;
      out_timeout_reg <= 1'b1;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign div_start   = (state_reg == ISSUE);
  assign div_x       = launch_reg.x;
  assign div_d       = launch_reg.d;
  assign out_valid   = out_valid_reg;
  assign out_res     = out_res_reg;
  assign out_tag     = out_tag_reg;
  assign out_special = out_special_reg;
  assign out_timeout = out_timeout_reg;

endmodule

// File: tb/tb_fphub_div_issue_ctrl.sv
// Directed bench for fphub_div_issue_ctrl with a behavioural divider stub and an in-order scoreboard.
module tb_fphub_div_issue_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_d;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [3:0]  out_tag;
  logic        out_special;
  logic        out_timeout;
  logic        div_start;
  logic [31:0] div_x;
  logic [31:0] div_d;
  logic [31:0] div_res;
  logic        div_finish;
  logic        div_computing;
  logic        div_special;
  logic [2:0]  occupancy;

  fphub_div_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_l(rst_l),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_d(in_d), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag),
    .out_special(out_special), .out_timeout(out_timeout),
    .div_start(div_start), .div_x(div_x), .div_d(div_d), .div_res(div_res),
    .div_finish(div_finish), .div_computing(div_computing), .div_special(div_special),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Divider stub: result is x^d, finish arrives lat_cfg cycles after the start pulse.
  int   lat_cfg   = 3;
  bit   hang      = 1'b0;
  logic stub_busy = 1'b0;
  int   stub_rem  = 0;

  always @(posedge clk) begin
    if (div_start) begin
      stub_busy <= 1'b1;
      stub_rem  <= lat_cfg;
    end else if (stub_busy) begin
      if (stub_rem <= 1) stub_busy <= 1'b0;
      else stub_rem <= stub_rem - 1;
    end
  end

  assign div_finish    = stub_busy && (stub_rem == 1) && !hang;
  assign div_computing = stub_busy;
  assign div_res       = div_x ^ div_d;
  assign div_special   = div_start && (div_d[30:0] == 31'd0);

  // Scoreboard: pending FIFO contents and launched-but-unreturned results.
  logic [31:0] iq_x[$];
  logic [31:0] iq_d[$];
  logic [3:0]  iq_tag[$];
  logic [31:0] rq_res[$];
  logic [3:0]  rq_tag[$];
  logic        rq_spec[$];
  logic        rq_to[$];

  int          rx_count    = 0;
  int          acc_count   = 0;
  int          start_count = 0;
  int          push_cyc    = 0;
  int          start_cyc   = 0;
  int          rise_cyc    = 0;
  logic [3:0]  rx_tags [0:63];
  logic [31:0] last_res;
  logic [3:0]  last_tag;
  logic        last_spec;
  logic        last_to;

  bit          waiting    = 1'b0;
  bit          prev_start = 1'b0;
  bit          prev_hold  = 1'b0;
  bit          prev_ov    = 1'b0;
  logic [31:0] lx, ld, h_res;
  logic [3:0]  h_tag;

  always @(negedge clk) begin
    if (!rst_l) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_div_start", div_start, 0);
      chk("rst_div_xd", {div_x, div_d}, 0);
      chk("rst_out_fields", {out_res, out_tag, out_special, out_timeout}, 0);
      iq_x.delete(); iq_d.delete(); iq_tag.delete();
      rq_res.delete(); rq_tag.delete(); rq_spec.delete(); rq_to.delete();
      waiting = 0; prev_start = 0; prev_hold = 0; prev_ov = 0;
    end else begin
      if (div_start) begin
        chk("start_not_back_to_back", prev_start, 0);
        if (iq_x.size() == 0) begin
          chk("start_with_empty_model", 1, 0);
        end else begin
          lx = iq_x.pop_front();
          ld = iq_d.pop_front();
          chk("launch_x", div_x, lx);
          chk("launch_d", div_d, ld);
          rq_res.push_back(hang ? 32'd0 : (lx ^ ld));
          rq_tag.push_back(iq_tag.pop_front());
          rq_spec.push_back(ld[30:0] == 31'd0);
          rq_to.push_back(hang);
          waiting = 1;
          start_cyc = cyc;
          start_count++;
        end
      end else if (waiting) begin
        chk("launch_stable", {div_x, div_d}, {lx, ld});
      end
      chk("occupancy", occupancy, iq_x.size());
      chk("in_ready", in_ready, (iq_x.size() < DEPTH) ? 1 : 0);
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {out_res, out_tag}, {h_res, h_tag});
      end
      if (out_valid) begin
        chk("out_expected", (rq_res.size() > 0) ? 1 : 0, 1);
        if (!prev_ov) begin
          rise_cyc = cyc;
          waiting  = 0;
        end
      end
      if (out_valid && out_ready && rq_res.size() > 0) begin
        chk("out_tag", out_tag, rq_tag[0]);
        chk("out_timeout", out_timeout, rq_to[0]);
        chk("out_res", out_res, rq_res[0]);
        if (!rq_to[0]) chk("out_special", out_special, rq_spec[0]);
        last_res = out_res; last_tag = out_tag; last_spec = out_special; last_to = out_timeout;
        rx_tags[rx_count % 64] = out_tag;
        rx_count++;
        void'(rq_res.pop_front()); void'(rq_tag.pop_front());
        void'(rq_spec.pop_front()); void'(rq_to.pop_front());
      end
      prev_hold  = out_valid && !out_ready;
      h_res      = out_res;
      h_tag      = out_tag;
      prev_ov    = out_valid;
      prev_start = div_start;
      if (in_valid && in_ready) begin
        iq_x.push_back(in_x);
        iq_d.push_back(in_d);
        iq_tag.push_back(in_tag);
        push_cyc = cyc;
        acc_count++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] x, input logic [31:0] d, input logic [3:0] tag);
    int w;
    in_valid = 1; in_x = x; in_d = d; in_tag = tag;
    w = 0;
    while (!in_ready && w < 300) begin step(); w++; end
    if (!in_ready) chk("push_wait", 0, 1);
    else step();
    in_valid = 0;
  endtask

  task automatic wait_rx(input int target, input int limit);
    int w;
    w = 0;
    while (rx_count < target && w < limit) begin step(); w++; end
    if (rx_count < target) chk("rx_wait", rx_count, target);
  endtask

  initial begin
    int base, acc0, w;
    bit blocked;
    rst_l = 0; in_valid = 0; in_x = 0; in_d = 0; in_tag = 0; out_ready = 1;
    repeat (3) step();
    chk("reset_in_ready_lit", in_ready, 1);
    chk("reset_out_valid_lit", out_valid, 0);
    chk("reset_occupancy_lit", occupancy, 0);
    rst_l = 1;
    step();

    // 1: single request, latency push->start
    lat_cfg = 3;
    push(32'h4000_0000, 32'h3F80_0000, 4'd3);
    wait_rx(1, 50);
    chk("t1_res", last_res, 32'h7F80_0000);
    chk("t1_tag", last_tag, 3);
    chk("t1_flags", {last_spec, last_to}, 2'b00);
    chk("t1_push_to_start", start_cyc - push_cyc, 2);

    // 2: zero divisor -> special, fastest completion
    lat_cfg = 1;
    push(32'h3F80_0000, 32'h0000_0000, 4'd7);
    wait_rx(2, 50);
    chk("t2_special", last_spec, 1);
    chk("t2_res", last_res, 32'h3F80_0000);
    chk("t2_start_to_valid", rise_cyc - start_cyc, 2);
    chk("t2_push_to_valid", rise_cyc - push_cyc, 4);

    // 3: backpressure, DEPTH+1 accepted, in-order release
    lat_cfg = 3; out_ready = 0; base = rx_count; acc0 = acc_count; blocked = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_x = 32'h4000_0000 | i; in_d = 32'h3F80_0000 + (i << 4); in_tag = 4'(i);
      w = 0;
      while (!in_ready && w < 40) begin step(); w++; end
      if (!in_ready) begin blocked = 1; break; end
      step();
    end
    chk("t3_accepted_before_full", acc_count - acc0, 5);
    repeat (200) step();
    chk("t3_in_ready_held_low", in_ready, 0);
    out_ready = 1;
    if (blocked) begin
      w = 0;
      while (!in_ready && w < 50) begin step(); w++; end
      if (!in_ready) chk("t3_release_wait", 0, 1);
      else step();
    end
    in_valid = 0;
    wait_rx(base + 6, 200);
    for (int i = 0; i < 6; i++) chk("t3_tag_order", rx_tags[(base + i) % 64], i);

    // 4: divider never finishes -> timeout, then normal request
    hang = 1; lat_cfg = 80;
    push(32'h1234_5678, 32'h4000_0000, 4'd9);
    wait_rx(rx_count + 1, 200);
    chk("t4_timeout", last_to, 1);
    chk("t4_res_zero", last_res, 0);
    chk("t4_tag", last_tag, 9);
    chk("t4_start_to_valid", rise_cyc - start_cyc, TIMEOUT + 1);
    hang = 0; lat_cfg = 2;
    push(32'h4100_0000, 32'h4000_0000, 4'd10);
    wait_rx(rx_count + 1, 200);
    chk("t4_recover_tag", last_tag, 10);
    chk("t4_recover_to", last_to, 0);

    // 5: simultaneous push and pop at occupancy 3
    lat_cfg = 1; out_ready = 0; base = rx_count;
    push(32'h4000_0001, 32'h3F80_0001, 4'd1);
    w = 0;
    while (!out_valid && w < 20) begin step(); w++; end
    push(32'h4000_0002, 32'h3F80_0002, 4'd2);
    push(32'h4000_0003, 32'h3F80_0003, 4'd3);
    push(32'h4000_0004, 32'h3F80_0004, 4'd4);
    step(); step();
    chk("t5_occ_before", occupancy, 3);
    out_ready = 1;
    step();
    out_ready = 0;
    in_valid = 1; in_x = 32'h4000_0005; in_d = 32'h3F80_0005; in_tag = 4'd5;
    chk("t5_occ_pushpop_cycle", occupancy, 3);
    chk("t5_in_ready", in_ready, 1);
    step();
    in_valid = 0;
    chk("t5_occ_after", occupancy, 3);
    chk("t5_issue", div_start, 1);
    out_ready = 1;
    wait_rx(base + 5, 200);
    for (int i = 0; i < 5; i++) chk("t5_tag_order", rx_tags[(base + i) % 64], i + 1);

    // 6: reset during WAIT, late finish ignored
    lat_cfg = 6; base = rx_count;
    push(32'h4000_0000, 32'h4040_0000, 4'd2);
    push(32'h4000_0000, 32'h4080_0000, 4'd4);
    push(32'h4000_0000, 32'h40A0_0000, 4'd6);
    rst_l = 0;
    step();
    rst_l = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t6_out_valid_low", out_valid, 0);
      chk("t6_occ_zero", occupancy, 0);
    end
    chk("t6_no_results", rx_count, base);
    lat_cfg = 2;
    push(32'h4000_0000, 32'h3F80_0000, 4'd8);
    wait_rx(base + 1, 100);
    chk("t6_recover_tag", last_tag, 8);

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog");
  end

endmodule
